// File: rtl/fdiv_arbiter_if.sv
// Requester-side handshake bundle for fdiv_arbiter: two operand request
// channels and two response channels sharing a single result bus.
interface fdiv_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp_data;

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data
  );
endinterface

// File: rtl/fdiv_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-precision divider
// between two requesters; divide-by-zero is answered locally without a divide.
module fdiv_arbiter #(
  parameter int unsigned DIV_LATENCY = 14
) (
  input  logic          clk,
  input  logic          reset,
  fdiv_arbiter_if.slave bus,
  output logic          busy,
  output logic          div_start,
  output logic          div_rsign,
  output logic [7:0]    div_rexp,
  output logic [22:0]   div_rmant,
  output logic          div_dsign,
  output logic [7:0]    div_dexp,
  output logic [22:0]   div_dmant,
  input  logic [31:0]   div_q
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               prio;
  logic               tag;
  logic               rst_dly;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       res_q;
  logic [CNT_W-1:0]   cnt;

  logic               out_en;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               zero_div;
  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;
  logic               ready0;
  logic               ready1;
  logic               start;
  logic               resp0;
  logic               resp1;

  // Outputs are forced low while reset is sampled and for one cycle after it
  always_comb begin
    out_en = !reset && !rst_dly;
  end

  // Round-robin grant: the priority holder wins if valid, else the other one
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!prio) begin
      grant0 = bus.req0_valid;
      grant1 = !bus.req0_valid && bus.req1_valid;
    end else begin
      grant1 = bus.req1_valid;
      grant0 = !bus.req1_valid && bus.req0_valid;
    end
    sel_a    = grant1 ? bus.req1_a : bus.req0_a;
    sel_b    = grant1 ? bus.req1_b : bus.req0_b;
    zero_div = (sel_b[W-2:0] == '0);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and decoded controls
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    start     = 1'b0;
    resp0     = 1'b0;
    resp1     = 1'b0;
    case (state)
      IDLE: begin
        if (out_en && (grant0 || grant1)) begin
          accept    = 1'b1;
          ready0    = grant0;
          ready1    = grant1;
          state_nxt = zero_div ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        start     = out_en;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp0 = out_en && !tag;
        resp1 = out_en && tag;
        // Only the tagged requester's ready can retire the response
        if (tag ? bus.resp1_ready : bus.resp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, tag/priority, latency counter and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_dly <= 1'b1;
      prio    <= 1'b0;
      tag     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt     <= '0;
    end else begin
      rst_dly <= 1'b0;
      if (accept) begin
        tag  <= grant1;
        prio <= !grant1;
        a_q  <= sel_a;
        b_q  <= sel_b;
        if (zero_div) begin
          res_q <= {sel_a[W-1] ^ sel_b[W-1], 8'hFF, 23'h0};
        end
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(DIV_LATENCY - 1);
      end else if (state == WAIT) begin
        if (cnt == '0) begin
          res_q <= div_q;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  // Output drive; everything is gated so reset cycles present all zeros
  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.resp0_valid = resp0;
  assign bus.resp1_valid = resp1;
  assign bus.resp_data   = out_en ? res_q : '0;

  assign busy      = out_en && (state != IDLE);
  assign div_start = start;
  assign div_rsign = out_en & a_q[31];
  assign div_rexp  = out_en ? a_q[30:23] : 8'h0;
  assign div_rmant = out_en ? a_q[22:0]  : 23'h0;
  assign div_dsign = out_en & b_q[31];
  assign div_dexp  = out_en ? b_q[30:23] : 8'h0;
  assign div_dmant = out_en ? b_q[22:0]  : 23'h0;

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 14, meaning the cycles from the div_start cycle to the cycle in which div_q is valid (range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port reqN_valid (N=0,1), input, 1, requester N presents an operand pair.
REQ-005 SHALL have port reqN_ready (N=0,1), output, 1, requester N's pair is accepted this cycle.
REQ-006 SHALL have port reqN_a (N=0,1), input, 32, the IEEE-754 single dividend.
REQ-007 SHALL have port reqN_b (N=0,1), input, 32, the IEEE-754 single divisor.
REQ-008 SHALL have port respN_valid (N=0,1), output, 1, the result for requester N is on resp_data.
REQ-009 SHALL have port respN_ready (N=0,1), input, 1, requester N consumes the result.
REQ-010 SHALL have port resp_data, output, 32, the quotient, shared by both requesters.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port div_start, output, 1, the divider start pulse.
REQ-013 SHALL have port div_rsign, output, 1, dividend sign (a[31]).
REQ-014 SHALL have port div_rexp, output, 8, dividend exponent (a[30:23]).
REQ-015 SHALL have port div_rmant, output, 23, dividend mantissa (a[22:0]).
REQ-016 SHALL have port div_dsign, output, 1, divisor sign (b[31]).
REQ-017 SHALL have port div_dexp, output, 8, divisor exponent (b[30:23]).
REQ-018 SHALL have port div_dmant, output, 23, divisor mantissa (b[22:0]).
REQ-019 SHALL have port div_q, input, 32, the divider result.

Function
REQ-020 SHALL implement an FSM with the states IDLE, ISSUE, WAIT and RESP.
REQ-021 SHALL make reqN_ready combinational: high only in IDLE when N is the grantee.
REQ-022 SHALL select the grantee round-robin: the requester with priority wins if it is valid, otherwise the other requester wins if it is valid.
REQ-023 SHALL pass priority to the other requester after every grant, so one requester alone is served back-to-back without stalling.
REQ-024 SHALL, on acceptance (reqN_valid && reqN_ready) in IDLE, register a, b and the tag N.
REQ-025 SHALL drive the div_* operand outputs from those registers, stable until the next acceptance.
REQ-026 SHALL, when the divisor is zero (b[30:0]==0), go IDLE->RESP directly, never assert div_start, and set the result to {a[31]^b[31], 8'hFF, 23'h0}.
REQ-027 SHALL otherwise go IDLE->ISSUE.
REQ-028 SHALL, in ISSUE, hold div_start high for exactly that one cycle, load the cycle counter with DIV_LATENCY-1, and go to WAIT.
REQ-029 SHALL, in WAIT, decrement the counter each cycle.
REQ-030 SHALL, in the WAIT cycle in which the counter equals 0, register div_q as the result and go to RESP.
REQ-031 SHALL place div_q sampling at the edge ending cycle S+DIV_LATENCY, where S is the div_start cycle.
REQ-032 SHALL, for a normal division accepted at the edge ending cycle T, assert respN_valid from cycle T+DIV_LATENCY+2.
REQ-033 SHALL, in RESP, assert respN_valid for the registered tag only, keep the other respN_valid low, and hold resp_data stable.
REQ-034 SHALL leave RESP for IDLE on the cycle that respN_ready is high for the tagged requester; respN_ready for the untagged requester SHALL be ignored.
REQ-035 SHALL keep both reqN_ready low in ISSUE, WAIT and RESP; new requests wait and are never dropped.
REQ-036 SHALL not combinationally depend on div_q for any output.

Reset
REQ-037 SHALL, on a reset cycle, enter IDLE, give priority to requester 0, and clear the counter, the tag, and the a, b and result registers; reset in any state is included.
REQ-038 SHALL drive every output 0 during reset and in the first cycle after it; an in-flight divide is discarded and produces no respN_valid.

Verification
REQ-039 SHALL verify a single request: req0 a=0x40400000, b=0x40000000, model q=0x3FC00000 at latency 14 -> req0_ready in cycle T, div_start only in cycle T+1, div_rexp=0x80, div_dexp=0x80, resp0_valid with resp_data=0x3FC00000 in cycle T+16, resp1_valid=0.
REQ-040 SHALL verify contention: both reqN_valid high in the first cycle after reset -> requester 0 served first, requester 1 accepted in the IDLE cycle after resp0 handshake.
REQ-041 SHALL verify the zero divisor: a=0xC0000000, b=0x80000000 -> div_start never asserted, resp_data=0x7F800000 in cycle T+1.
REQ-042 SHALL verify back-pressure: respN_ready low for 5 cycles -> respN_valid and resp_data held, busy=1, both reqN_ready=0.
REQ-043 SHALL verify reset in WAIT: reset at counter=5 -> in the next cycle all outputs are 0 and state is IDLE, and no response follows.
REQ-044 SHALL verify a lone requester: three req1 requests back-to-back -> each accepted in the first IDLE cycle, tags all 1, three ordered responses.
